// File: rtl/svm_hwf_pkg.sv
// Shared helpers for the time-multiplexed HWF SVM stage.
// Provides a constant clog2, derived width helpers and the FSM state encoding.
package svm_hwf_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Address/index width that never collapses to zero bits.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (clog2(depth) == 0) ? 1 : clog2(depth);
  endfunction

  // Width of a full-vector L1 distance.
  function automatic int unsigned dist_width(input int unsigned xlen, input int unsigned npix);
    return xlen + clog2(npix + 1);
  endfunction

  // Accumulator width: NUM_OF_SV alpha terms plus the bias can never overflow it.
  function automatic int unsigned acc_width(input int unsigned alpha_w, input int unsigned nsv);
    return alpha_w + clog2(nsv + 1) + 1;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StDist,
    StKern,
    StDecide,
    StDone
  } state_e;

endpackage

// File: rtl/hwf_l1_lane_sum.sv
// Combinational L1 partial sum over one beat of LANES pixels.
// Ports:
//   x   - LANES test pixels, lane l at [l*XLEN_PIXEL +: XLEN_PIXEL]
//   sv  - LANES support-vector pixels, same packing
//   sum - sum of |x_l - sv_l| over all lanes
module hwf_l1_lane_sum
  import svm_hwf_pkg::*;
#(
  parameter int unsigned XLEN_PIXEL = 8,
  parameter int unsigned LANES      = 16,
  localparam int unsigned SUM_W     = XLEN_PIXEL + clog2(LANES + 1)
) (
  input  logic [LANES*XLEN_PIXEL-1:0] x,
  input  logic [LANES*XLEN_PIXEL-1:0] sv,
  output logic [SUM_W-1:0]            sum
);

  always_comb begin
    sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (x[l*XLEN_PIXEL +: XLEN_PIXEL] >= sv[l*XLEN_PIXEL +: XLEN_PIXEL]) begin
        sum = sum + SUM_W'(x[l*XLEN_PIXEL +: XLEN_PIXEL] - sv[l*XLEN_PIXEL +: XLEN_PIXEL]);
      end else begin
        sum = sum + SUM_W'(sv[l*XLEN_PIXEL +: XLEN_PIXEL] - x[l*XLEN_PIXEL +: XLEN_PIXEL]);
      end
    end
  end

endmodule

// File: rtl/svm_stage_hwf_seq.sv
// Time-multiplexed HWF SVM stage: evaluates K = 2^-(L1 >> GAMMA_SHIFT) against NUM_OF_SV
// streamed support vectors, LANES pixels per cycle, accumulates sign(alpha)*(|alpha| >> s),
// adds the bias and reports the class bit plus an escalate flag for the next cascade stage.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   in_valid/in_ready        - sample handshake (x_test, b, margin); ready only in IDLE
//   sv_rd_en/addr/data       - SV memory, data returns one cycle after sv_rd_en
//   alpha_rd_addr/data       - alpha memory, combinational read, addr = current SV index
//   out_valid/out_ready      - result handshake; y_class, escalate, decision held until taken
module svm_stage_hwf_seq
  import svm_hwf_pkg::*;
#(
  parameter int unsigned XLEN_PIXEL    = 8,
  parameter int unsigned NUM_OF_PIXELS = 784,
  parameter int unsigned NUM_OF_SV     = 10,
  parameter int unsigned LANES         = 16,
  parameter int unsigned ALPHA_W       = 16,
  parameter int unsigned GAMMA_SHIFT   = 4,
  localparam int unsigned BEATS        = NUM_OF_PIXELS / LANES,
  localparam int unsigned DIST_W       = dist_width(XLEN_PIXEL, NUM_OF_PIXELS),
  localparam int unsigned ACC_W        = acc_width(ALPHA_W, NUM_OF_SV),
  localparam int unsigned SV_ADDR_W    = addr_width(NUM_OF_SV * BEATS),
  localparam int unsigned SV_IDX_W     = addr_width(NUM_OF_SV)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0] x_test,
  input  logic signed [ALPHA_W-1:0]           b,
  input  logic [ACC_W-2:0]                    margin,
  output logic                                sv_rd_en,
  output logic [SV_ADDR_W-1:0]                sv_rd_addr,
  input  logic [LANES*XLEN_PIXEL-1:0]         sv_rd_data,
  output logic [SV_IDX_W-1:0]                 alpha_rd_addr,
  input  logic signed [ALPHA_W-1:0]           alpha_rd_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                y_class,
  output logic                                escalate,
  output logic signed [ACC_W-1:0]             decision
);

  localparam int unsigned LANE_BITS = LANES * XLEN_PIXEL;
  localparam int unsigned SUM_W     = XLEN_PIXEL + clog2(LANES + 1);
  localparam int unsigned BEAT_W    = addr_width(BEATS + 1);

  if (NUM_OF_PIXELS % LANES != 0) begin : g_bad_lanes
    $error("NUM_OF_PIXELS must be a multiple of LANES");
  end

  state_e                             state_q, state_d;
  logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0] x_q;
  logic signed [ALPHA_W-1:0]          b_q;
  logic [ACC_W-2:0]                   margin_q;
  logic [SV_IDX_W-1:0]                sv_idx_q;
  logic [BEAT_W-1:0]                  beat_q;
  logic [DIST_W-1:0]                  dist_q;
  logic signed [ACC_W-1:0]            acc_q, decision_q;
  logic                               y_class_q, escalate_q;

  logic                               last_beat, last_sv;
  logic [BEAT_W-1:0]                  data_beat;
  logic [LANE_BITS-1:0]               x_beat;
  logic [SUM_W-1:0]                   lane_sum;
  logic [DIST_W-1:0]                  shift;
  logic                               alpha_neg;
  logic [ALPHA_W-1:0]                 alpha_mag, mag_shifted;
  logic [ACC_W-1:0]                   term_mag;
  logic signed [ACC_W-1:0]            term, dec_sum;
  logic [ACC_W-1:0]                   dec_abs;

  assign last_beat = (beat_q == BEAT_W'(BEATS));
  assign last_sv   = (sv_idx_q == SV_IDX_W'(NUM_OF_SV - 1));

  // Returned data belongs to the beat requested one cycle earlier.
  assign data_beat = beat_q - BEAT_W'(1);

  always_comb begin
    x_beat = '0;
    for (int unsigned bb = 0; bb < BEATS; bb++) begin
      if (data_beat == BEAT_W'(bb)) x_beat = x_q[bb*LANE_BITS +: LANE_BITS];
    end
  end

  hwf_l1_lane_sum #(
    .XLEN_PIXEL(XLEN_PIXEL),
    .LANES     (LANES)
  ) u_lane_sum (
    .x  (x_beat),
    .sv (sv_rd_data),
    .sum(lane_sum)
  );

  // Kernel term: shift the magnitude so a negative alpha decays to 0, not -1.
  always_comb begin
    shift       = dist_q >> GAMMA_SHIFT;
    alpha_neg   = alpha_rd_data[ALPHA_W-1];
    alpha_mag   = alpha_neg ? (~alpha_rd_data + ALPHA_W'(1)) : alpha_rd_data;
    mag_shifted = (shift >= DIST_W'(ALPHA_W)) ? '0 : (alpha_mag >> shift);
    term_mag    = ACC_W'(mag_shifted);
    term        = alpha_neg ? -term_mag : term_mag;
  end

  always_comb begin
    dec_sum = acc_q + ACC_W'(b_q);
    dec_abs = dec_sum[ACC_W-1] ? -dec_sum : dec_sum;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StDist;
      StDist:   if (last_beat) state_d = StKern;
      StKern:   state_d = last_sv ? StDecide : StDist;
      StDecide: state_d = StDone;
      StDone:   if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q        <= '0;
      b_q        <= '0;
      margin_q   <= '0;
      sv_idx_q   <= '0;
      beat_q     <= '0;
      dist_q     <= '0;
      acc_q      <= '0;
      decision_q <= '0;
      y_class_q  <= 1'b0;
      escalate_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q      <= x_test;
            b_q      <= b;
            margin_q <= margin;
            sv_idx_q <= '0;
            beat_q   <= '0;
            dist_q   <= '0;
            acc_q    <= '0;
          end
        end
        StDist: begin
          if (beat_q != '0) dist_q <= dist_q + DIST_W'(lane_sum);
          beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
        end
        StKern: begin
          acc_q  <= acc_q + term;
          dist_q <= '0;
          if (!last_sv) sv_idx_q <= sv_idx_q + SV_IDX_W'(1);
        end
        StDecide: begin
          decision_q <= dec_sum;
          y_class_q  <= ~dec_sum[ACC_W-1];
          escalate_q <= (dec_abs < {1'b0, margin_q});
        end
        StDone:  ;
        default: ;
      endcase
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign sv_rd_en      = (state_q == StDist) && !last_beat;
  assign sv_rd_addr    = SV_ADDR_W'(32'(sv_idx_q) * BEATS + 32'(beat_q));
  assign alpha_rd_addr = sv_idx_q;
  assign out_valid     = (state_q == StDone);
  assign y_class       = y_class_q;
  assign escalate      = escalate_q;
  assign decision      = decision_q;

endmodule

// File: tb/tb_svm_stage_hwf_seq.sv
module tb_svm_stage_hwf_seq;

  localparam int unsigned XLEN  = 8;
  localparam int unsigned NPIX  = 4;
  localparam int unsigned NSV   = 2;
  localparam int unsigned LANES = 2;
  localparam int unsigned AW    = 16;
  localparam int unsigned GS    = 2;
  localparam int unsigned ACC_W = 19;
  localparam int          LAT   = 9;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid, in_ready;
  logic [NPIX*XLEN-1:0]    x_test;
  logic signed [AW-1:0]    b;
  logic [ACC_W-2:0]        margin;
  logic                    sv_rd_en;
  logic [1:0]              sv_rd_addr;
  logic [LANES*XLEN-1:0]   sv_rd_data;
  logic [0:0]              alpha_rd_addr;
  logic signed [AW-1:0]    alpha_rd_data;
  logic                    out_valid, out_ready, y_class, escalate;
  logic signed [ACC_W-1:0] decision;

  always #5 clk = ~clk;

  svm_stage_hwf_seq #(
    .XLEN_PIXEL   (XLEN),
    .NUM_OF_PIXELS(NPIX),
    .NUM_OF_SV    (NSV),
    .LANES        (LANES),
    .ALPHA_W      (AW),
    .GAMMA_SHIFT  (GS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x_test       (x_test),
    .b            (b),
    .margin       (margin),
    .sv_rd_en     (sv_rd_en),
    .sv_rd_addr   (sv_rd_addr),
    .sv_rd_data   (sv_rd_data),
    .alpha_rd_addr(alpha_rd_addr),
    .alpha_rd_data(alpha_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .y_class      (y_class),
    .escalate     (escalate),
    .decision     (decision)
  );

  // Memory models: registered SV read, combinational alpha read.
  logic [LANES*XLEN-1:0] sv_mem    [4];
  logic signed [AW-1:0]  alpha_mem [2];

  always @(posedge clk) if (sv_rd_en) sv_rd_data <= sv_mem[sv_rd_addr];
  assign alpha_rd_data = alpha_mem[alpha_rd_addr];

  typedef struct {
    logic [7:0]           xv, s0, s1;
    logic signed [AW-1:0] a0, a1, bias;
    logic [ACC_W-2:0]     mrg;
    longint               exp_dec;
    bit                   exp_y, exp_esc;
  } vec_t;

  typedef struct {
    longint dec;
    bit     y, esc;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input int xv, input int s0, input int s1, input int a0,
                              input int a1, input int bias, input int mrg, input longint d,
                              input bit y, input bit e);
    vec_t v;
    v.xv = 8'(xv); v.s0 = 8'(s0); v.s1 = 8'(s1);
    v.a0 = AW'(a0); v.a1 = AW'(a1); v.bias = AW'(bias);
    v.mrg = (ACC_W-1)'(mrg);
    v.exp_dec = d; v.exp_y = y; v.exp_esc = e;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic start(input vec_t v, input bit push);
    exp_t e;
    @(negedge clk);
    sv_mem[0] = {2{v.s0}}; sv_mem[1] = {2{v.s0}};
    sv_mem[2] = {2{v.s1}}; sv_mem[3] = {2{v.s1}};
    alpha_mem[0] = v.a0; alpha_mem[1] = v.a1;
    x_test = {4{v.xv}}; b = v.bias; margin = v.mrg;
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    if (push) begin
      e.dec = v.exp_dec; e.y = v.exp_y; e.esc = v.exp_esc;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_decision"}, longint'(decision), e.dec);
      check({tag, "_y_class"}, y_class, longint'(e.y));
      check({tag, "_escalate"}, escalate, longint'(e.esc));
    end
  endtask

  initial begin
    int cyc;
    //            x   s0  s1   a0      a1    b     m   dec   y  esc
    vecs[0] = mk(10, 10, 12,  100,    -64,  -20,  50,   64, 1, 0);  // nominal
    vecs[1] = mk(10, 10, 12,  100,    -64,  -70,  50,   14, 1, 1);  // escalate
    vecs[2] = mk(10, 10, 12,  100,    -64,  -84,  50,    0, 1, 1);  // decision zero
    vecs[3] = mk(10, 10, 12,  100,    -64,  -85,  50,   -1, 0, 1);  // decision -1
    vecs[4] = mk( 0,  0, 255, 100, -32768,  -30,  50,   70, 1, 0);  // kernel underflow
    vecs[5] = mk(10, 10, 12,  100,    -64,  -70,   0,   14, 1, 0);  // margin 0
    vecs[6] = mk(10, 10, 12,  100,    -64, -134,  50,  -50, 0, 0);  // decision = -margin
    vecs[7] = mk(10, 10, 12, -100,    -64,    0,  50, -116, 0, 0);  // negative alpha, dist 0
    vecs[8] = mk(10, 10, 12,    5,     -3,    0,  10,    5, 1, 1);  // -3>>2 must be 0

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_test = '0; b = '0; margin = '0;
    for (int i = 0; i < 4; i++) sv_mem[i] = '0;
    for (int i = 0; i < 2; i++) alpha_mem[i] = '0;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_sv_rd_en", sv_rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_y_class", y_class, 0);
    check("rst_escalate", escalate, 0);
    check("rst_decision", longint'(decision), 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start(vecs[i], 1'b1);
      wait_out(cyc);
      check($sformatf("vec%0d_latency", i), cyc, LAT);
      compare_out($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_released", i), out_valid, 0);
    end

    // Backpressure: result held, new sample ignored until the handshake.
    out_ready = 1'b0;
    start(vecs[0], 1'b1);
    wait_out(cyc);
    check("bp_latency", cyc, LAT);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sv_rd_en", sv_rd_en, 0);
      check("bp_decision", longint'(decision), 64);
      if (i == 1) begin in_valid = 1'b1; b = -16'sd70; end
      if (i == 3) in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    compare_out("bp");
    @(posedge clk);
    #1;
    check("bp_done_out_valid", out_valid, 0);
    check("bp_done_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("bp_not_accepted", in_ready, 1);
    check("bp_no_read", sv_rd_en, 0);

    // Reset during the DIST phase of SV1.
    start(vecs[0], 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("mid_alpha_addr", alpha_rd_addr, 1);
    check("mid_sv_rd_en", sv_rd_en, 1);
    rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_sv_rd_en", sv_rd_en, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_decision", longint'(decision), 0);
    @(negedge clk) rst = 1'b1;
    start(vecs[0], 1'b1);
    wait_out(cyc);
    check("post_rst_latency", cyc, LAT);
    compare_out("post_rst");
    @(posedge clk);
    #1;

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/svm_stage_hwf_seq.md
Name: svm_stage_hwf_seq

Overview:
Parametrised, time-multiplexed successor to the fully parallel stage-1 HWF classifier. It evaluates the hardware-friendly kernel K = 2^-(L1 distance >> GAMMA_SHIFT) against NUM_OF_SV support vectors streamed from external memory, LANES pixels per cycle. It accumulates the alpha-weighted kernel terms, adds the bias and emits a class bit. It also emits an escalate flag telling the cascade that the next (stronger) stage must re-classify the sample.

Parameters:
XLEN_PIXEL, 8, unsigned pixel width
NUM_OF_PIXELS, 784, pixels per vector; must be a multiple of LANES (elaboration error otherwise)
NUM_OF_SV, 10, support vectors evaluated per sample
LANES, 16, pixels compared per cycle
ALPHA_W, 16, signed alpha/bias width
GAMMA_SHIFT, 4, right shift applied to the L1 distance to form the kernel exponent

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  x_test/b/margin valid
in_ready  out  1  high only in IDLE
x_test  in  NUM_OF_PIXELS*XLEN_PIXEL  test vector; pixel p at [p*XLEN_PIXEL +: XLEN_PIXEL]
b  in  ALPHA_W  signed bias
margin  in  ACC_W-1  unsigned escalation threshold
sv_rd_en  out  1  support-vector read strobe
sv_rd_addr  out  clog2(NUM_OF_SV*BEATS)  beat address = sv_idx*BEATS + beat
sv_rd_data  in  LANES*XLEN_PIXEL  read data, valid exactly 1 cycle after sv_rd_en
alpha_rd_addr  out  clog2(NUM_OF_SV)  current SV index
alpha_rd_data  in  ALPHA_W  signed alpha, combinational from alpha_rd_addr
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
y_class  out  1  1 when decision >= 0
escalate  out  1  1 when |decision| < margin
decision  out  ACC_W  signed decision value

Behaviour:
- Localparams: BEATS = NUM_OF_PIXELS/LANES; DIST_W = XLEN_PIXEL + clog2(NUM_OF_PIXELS+1); ACC_W = ALPHA_W + clog2(NUM_OF_SV+1) + 1. The accumulator cannot overflow; no saturation logic.
- Reset (rst low, asynchronous): state IDLE; all counters, accumulator and captured registers are zero. Outputs: in_ready=1, sv_rd_en=0, out_valid=0, y_class=0, escalate=0, decision=0.
- A reset asserted mid-operation aborts the sample. No partial output is produced.
- IDLE: in_ready=1. When in_valid is high, x_test, b and margin are captured, accumulator=0, sv_idx=0, and the FSM goes to DIST.
- DIST: lasts BEATS+1 cycles.
  - Cycles 0..BEATS-1 assert sv_rd_en with addr = sv_idx*BEATS + beat.
  - Cycles 1..BEATS each add the lane L1 sum of |x_p - sv_p| for the returned beat to dist.
  - Then go to KERN.
- KERN (1 cycle):
  - s = dist >> GAMMA_SHIFT.
  - term = sign(alpha) * (|alpha| >> s); term = 0 if s >= ALPHA_W. Magnitude shift, so a negative alpha never decays to -1.
  - acc += term; dist cleared.
  - If sv_idx == NUM_OF_SV-1, go to DECIDE; otherwise sv_idx++ and go to DIST.
- DECIDE (1 cycle): decision = acc + sign-extended b; y_class = (decision >= 0); escalate = (|decision| < margin). Go to DONE.
- DONE: out_valid=1 and outputs held stable until out_ready is high, then return to IDLE with out_valid=0. If out_ready is already high on entry, the handshake completes on the first DONE cycle.
- Latency: from the in_valid accept edge to out_valid = NUM_OF_SV*(BEATS+2) + 1 cycles.
- Throughput: one sample per latency + handshake. in_valid is ignored outside IDLE.
- alpha_rd_addr = sv_idx at all times; alpha is sampled in KERN.
- Boundary cases:
  - dist = 0 gives term = alpha.
  - decision exactly 0 gives y_class=1.
  - margin=0 forces escalate=0.
  - decision = -margin gives escalate=0.

Decomposition:
- Package svm_hwf_pkg: clog2 function, FSM state encoding (IDLE, DIST, KERN, DECIDE, DONE), width localparam helpers for DIST_W and ACC_W.
- Sub-module hwf_l1_lane_sum (combinational): sum of LANES absolute pixel differences. Output width XLEN_PIXEL + clog2(LANES+1).

Test Plan (params: NUM_OF_PIXELS=4, LANES=2, NUM_OF_SV=2, GAMMA_SHIFT=2, ALPHA_W=16):
- Nominal:
  - Stimulus: x all 10; SV0 all 10, alpha0=+100; SV1 all 12, alpha1=-64; b=-20; margin=50.
  - Response: decision=64, y_class=1, escalate=0, out_valid exactly 9 cycles after accept.
- Escalate:
  - Stimulus: same vectors, b=-70.
  - Response: decision=14, y_class=1, escalate=1.
- Negative/zero boundary:
  - Stimulus: b=-84.
  - Response: decision=0, y_class=1.
  - Stimulus: b=-85.
  - Response: decision=-1, y_class=0, escalate=1.
- Kernel underflow:
  - Stimulus: SV1 all 255, x all 0, alpha1=-32768 (dist=1020, s=255).
  - Response: term1=0; decision = 100 + b.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles; pulse in_valid during DONE.
  - Response: outputs stable, in_ready=0, second sample not accepted until after the out_ready handshake.
- Reset mid-run:
  - Stimulus: drop rst during DIST of SV1.
  - Response: immediately in_ready=1, sv_rd_en=0, out_valid=0. A fresh sample then yields the nominal result (64).
